// File: rtl/cv32e40x_xif_offload_ctrl_if.sv
// ---------------------------------------------------------------------------
// cv32e40x_xif_offload_ctrl_if
// Bundles the eXtension-interface (XIF) channels seen by the offload
// controller: issue request/response, commit and result.
//   master : core side (drives issue request, commit, result_ready)
//   slave  : coprocessor side (drives issue_ready/response, result)
// Parameters: X_ID_WIDTH (transaction id width), X_RFR_WIDTH (operand width).
// ---------------------------------------------------------------------------
interface cv32e40x_xif_offload_ctrl_if #(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_RFR_WIDTH = 32
);
    // issue channel
    logic                     issue_valid;
    logic                     issue_ready;
    logic [31:0]              issue_instr;
    logic [X_ID_WIDTH-1:0]    issue_id;
    logic [2*X_RFR_WIDTH-1:0] issue_rs;
    logic [1:0]               issue_rs_valid;
    logic                     issue_accept;
    logic                     issue_wb;
    // commit channel
    logic                     commit_valid;
    logic [X_ID_WIDTH-1:0]    commit_id;
    logic                     commit_kill;
    // result channel
    logic                     result_valid;
    logic                     result_ready;
    logic [X_ID_WIDTH-1:0]    result_id;
    logic [4:0]               result_rd;
    logic [X_RFR_WIDTH-1:0]   result_data;
    logic                     result_we;

    modport master (
        output issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
        input  issue_ready, issue_accept, issue_wb,
        output commit_valid, commit_id, commit_kill,
        input  result_valid, result_id, result_rd, result_data, result_we,
        output result_ready
    );

    modport slave (
        input  issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
        output issue_ready, issue_accept, issue_wb,
        input  commit_valid, commit_id, commit_kill,
        output result_valid, result_id, result_rd, result_data, result_we,
        input  result_ready
    );
endinterface

// File: rtl/cv32e40x_xif_offload_ctrl.sv
// ---------------------------------------------------------------------------
// cv32e40x_xif_offload_ctrl
// Core-side XIF initiator. Takes an offloaded instruction from the pipeline,
// issues it to the coprocessor, sends the commit/kill decision, tracks ids
// that still owe a result and forwards results to the register file through
// a one-entry buffer.
// Ports:
//   clk_i, rst_n            clock, asynchronous active-low reset
//   off_*                   pipeline offer (valid/ready, instr, rs1, rs2)
//   cmt_valid_i/cmt_kill_i  pipeline commit decision while in COMMIT
//   xif (master)            XIF issue/commit/result channels
//   wb_*                    register-file writeback handshake
//   illegal_o, err_o        one-cycle pulses: rejected instr / stray result
//   timeout_o               one-cycle pulse on issue watchdog expiry
// Optional feature: define XIF_OFFLOAD_TIMEOUT_EN to enable the issue
// watchdog (TIMEOUT_CYCLES); otherwise ISSUE waits forever, timeout_o = 0.
// ---------------------------------------------------------------------------
module cv32e40x_xif_offload_ctrl #(
    parameter int unsigned X_ID_WIDTH      = 4,
    parameter int unsigned X_RFR_WIDTH     = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   off_valid_i,
    output logic                   off_ready_o,
    input  logic [31:0]            off_instr_i,
    input  logic [X_RFR_WIDTH-1:0] off_rs1_i,
    input  logic [X_RFR_WIDTH-1:0] off_rs2_i,
    input  logic                   cmt_valid_i,
    input  logic                   cmt_kill_i,
    cv32e40x_xif_offload_ctrl_if.master xif,
    output logic                   wb_valid_o,
    input  logic                   wb_ready_i,
    output logic [4:0]             wb_rd_o,
    output logic [X_RFR_WIDTH-1:0] wb_data_o,
    output logic                   illegal_o,
    output logic                   err_o,
    output logic                   timeout_o
);
    localparam int unsigned NUM_IDS = 1 << X_ID_WIDTH;
    localparam int unsigned CNT_W   = $clog2(NUM_IDS + 1);
    localparam logic [CNT_W-1:0]      MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
    localparam logic [NUM_IDS-1:0]    ONE_HOT_C = NUM_IDS'(1);
    localparam logic [X_ID_WIDTH-1:0] ID_ONE_C  = X_ID_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Population count of the pending table.
    function automatic logic [CNT_W-1:0] count_ones(input logic [NUM_IDS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    state_e                 state_q;
    logic [X_ID_WIDTH-1:0]  next_id_q;
    logic [X_ID_WIDTH-1:0]  issued_id_q;
    logic [31:0]            instr_q;
    logic [X_RFR_WIDTH-1:0] rs1_q;
    logic [X_RFR_WIDTH-1:0] rs2_q;
    logic                   accept_q;
    logic                   wb_q;
    logic [NUM_IDS-1:0]     pending_q;
    logic [NUM_IDS-1:0]     pending_d;
    logic                   buf_valid_q;
    logic [4:0]             buf_rd_q;
    logic [X_RFR_WIDTH-1:0] buf_data_q;

    logic [CNT_W-1:0]       pending_cnt_s;
    logic                   off_ready_s;
    logic                   off_hs_s;
    logic                   issue_hs_s;
    logic                   commit_fire_s;
    logic                   commit_kill_s;
    logic                   pend_set_s;
    logic                   result_ready_s;
    logic                   res_hs_s;
    logic                   res_hit_s;
    logic                   buf_load_s;
    logic                   timeout_s;
    logic [NUM_IDS-1:0]     set_mask_s;
    logic [NUM_IDS-1:0]     clr_mask_s;

    assign pending_cnt_s = count_ones(pending_q);
    // The id about to be issued must not still owe a result, or results
    // for two different instructions would alias.
    assign off_ready_s   = (state_q == IDLE) && (pending_cnt_s < MAX_OUT_C)
                           && !pending_q[next_id_q];
    assign off_hs_s      = off_ready_s && off_valid_i;
    assign issue_hs_s    = (state_q == ISSUE) && xif.issue_ready;
    // A rejected instruction is killed without waiting for the pipeline.
    assign commit_fire_s = (state_q == COMMIT) && (!accept_q || cmt_valid_i);
    assign commit_kill_s = !accept_q || cmt_kill_i;
    assign pend_set_s    = commit_fire_s && !commit_kill_s && wb_q;

    assign result_ready_s = !buf_valid_q || wb_ready_i;
    assign res_hs_s       = xif.result_valid && result_ready_s;
    // pending_q still holds the pre-commit value, so a result racing its own
    // commit is seen as non-pending and flagged.
    assign res_hit_s      = pending_q[xif.result_id];
    assign buf_load_s     = res_hs_s && res_hit_s && xif.result_we;

    // Clear is applied before set, so a same-cycle commit of the same id keeps it pending.
    assign clr_mask_s = res_hs_s   ? (ONE_HOT_C << xif.result_id) : '0;
    assign set_mask_s = pend_set_s ? (ONE_HOT_C << issued_id_q)   : '0;
    assign pending_d  = (pending_q & ~clr_mask_s) | set_mask_s;

`ifdef XIF_OFFLOAD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST_C = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q;

    // Expires in the TIMEOUT_CYCLES-th ISSUE cycle without issue_ready.
    assign timeout_s = (state_q == ISSUE) && !xif.issue_ready && (to_cnt_q == TO_LAST_C);

    // Watchdog counter: counts ISSUE cycles, cleared everywhere else.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if ((state_q == ISSUE) && !issue_hs_s && !timeout_s) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_q <= '0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Offload FSM, id allocation, pending table and writeback buffer.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            next_id_q   <= '0;
            issued_id_q <= '0;
            instr_q     <= 32'h0000_0000;
            rs1_q       <= '0;
            rs2_q       <= '0;
            accept_q    <= 1'b0;
            wb_q        <= 1'b0;
            pending_q   <= '0;
            buf_valid_q <= 1'b0;
            buf_rd_q    <= 5'd0;
            buf_data_q  <= '0;
        end else begin
            pending_q <= pending_d;

            if (buf_load_s) begin
                buf_valid_q <= 1'b1;
                buf_rd_q    <= xif.result_rd;
                buf_data_q  <= xif.result_data;
            end else if (wb_ready_i) begin
                buf_valid_q <= 1'b0;
            end else begin
                buf_valid_q <= buf_valid_q;
            end

            case (state_q)
                IDLE: begin
                    if (off_hs_s) begin
                        instr_q <= off_instr_i;
                        rs1_q   <= off_rs1_i;
                        rs2_q   <= off_rs2_i;
                        state_q <= ISSUE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    if (issue_hs_s) begin
                        accept_q    <= xif.issue_accept;
                        wb_q        <= xif.issue_wb;
                        issued_id_q <= next_id_q;
                        next_id_q   <= next_id_q + ID_ONE_C;
                        state_q     <= COMMIT;
                    end
`ifdef XIF_OFFLOAD_TIMEOUT_EN
                    else if (timeout_s) begin
                        state_q <= IDLE;
                    end
`endif
                    else begin
                        state_q <= ISSUE;
                    end
                end
                COMMIT: begin
                    if (commit_fire_s) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= COMMIT;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign off_ready_o        = off_ready_s;
    assign xif.issue_valid    = (state_q == ISSUE);
    assign xif.issue_instr    = instr_q;
    assign xif.issue_id       = next_id_q;
    assign xif.issue_rs       = {rs2_q, rs1_q};
    assign xif.issue_rs_valid = (state_q == ISSUE) ? 2'b11 : 2'b00;
    assign xif.commit_valid   = commit_fire_s;
    assign xif.commit_id      = issued_id_q;
    assign xif.commit_kill    = commit_kill_s;
    assign xif.result_ready   = result_ready_s;
    assign wb_valid_o         = buf_valid_q;
    assign wb_rd_o            = buf_rd_q;
    assign wb_data_o          = buf_data_q;
    assign illegal_o          = (issue_hs_s && !xif.issue_accept) || timeout_s;
    assign err_o              = res_hs_s && !res_hit_s;
    assign timeout_o          = timeout_s;

endmodule

// File: tb/tb_cv32e40x_xif_offload_ctrl.sv
module tb_cv32e40x_xif_offload_ctrl;
    localparam int IDW  = 4;
    localparam int RW   = 32;
    localparam int MAXO = 2;
    localparam int NIDS = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        off_valid_i, off_ready_o;
    logic [31:0] off_instr_i, off_rs1_i, off_rs2_i;
    logic        cmt_valid_i, cmt_kill_i;
    logic        wb_valid_o, wb_ready_i;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        illegal_o, err_o, timeout_o;

    cv32e40x_xif_offload_ctrl_if #(.X_ID_WIDTH(IDW), .X_RFR_WIDTH(RW)) xif ();

    cv32e40x_xif_offload_ctrl #(
        .X_ID_WIDTH(IDW), .X_RFR_WIDTH(RW), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_i(clk), .rst_n(rst_n),
        .off_valid_i(off_valid_i), .off_ready_o(off_ready_o),
        .off_instr_i(off_instr_i), .off_rs1_i(off_rs1_i), .off_rs2_i(off_rs2_i),
        .cmt_valid_i(cmt_valid_i), .cmt_kill_i(cmt_kill_i),
        .xif(xif),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .illegal_o(illegal_o), .err_o(err_o), .timeout_o(timeout_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One in-flight instruction at most: offered (m_busy), then issued
    // (m_issued) waiting for its commit decision.
    bit             m_busy, m_issued, m_acc, m_wb;
    logic [31:0]    m_instr, m_rs1, m_rs2;
    int             m_next, m_id;
    bit [NIDS-1:0]  m_pend;
    bit             m_bufv;
    logic [4:0]     m_rd;
    logic [31:0]    m_data;

    always @(negedge clk) begin
        int  cnt;
        bit  e_or, e_iv, e_cv, e_ck, e_rr, r_hs, hit, e_err, e_ill;
        if (!rst_n) begin
            m_busy <= 1'b0; m_issued <= 1'b0; m_next <= 0; m_id <= 0;
            m_pend <= '0; m_bufv <= 1'b0; m_acc <= 1'b0; m_wb <= 1'b0;
        end else begin
            cnt = 0;
            for (int i = 0; i < NIDS; i++) cnt += int'(m_pend[i]);
            e_or  = !m_busy && (cnt < MAXO) && !m_pend[m_next];
            e_iv  = m_busy && !m_issued;
            e_cv  = m_busy && m_issued && (!m_acc || cmt_valid_i);
            e_ck  = !m_acc || cmt_kill_i;
            e_rr  = !m_bufv || wb_ready_i;
            r_hs  = xif.result_valid && e_rr;
            hit   = m_pend[xif.result_id];
            e_err = r_hs && !hit;
            e_ill = e_iv && xif.issue_ready && !xif.issue_accept;

            check("off_ready", off_ready_o, e_or);
            check("issue_valid", xif.issue_valid, e_iv);
            check("illegal", illegal_o, e_ill);
            check("commit_valid", xif.commit_valid, e_cv);
            check("result_ready", xif.result_ready, e_rr);
            check("err", err_o, e_err);
            check("wb_valid", wb_valid_o, m_bufv);
            check("timeout", timeout_o, 1'b0);
            if (e_iv) begin
                check("issue_id", xif.issue_id, m_next);
                check("issue_instr", xif.issue_instr, m_instr);
                check("issue_rs", xif.issue_rs, {m_rs2, m_rs1});
                check("issue_rs_valid", xif.issue_rs_valid, 2'b11);
            end
            if (e_cv) begin
                check("commit_id", xif.commit_id, m_id);
                check("commit_kill", xif.commit_kill, e_ck);
            end
            if (m_bufv) begin
                check("wb_rd", wb_rd_o, m_rd);
                check("wb_data", wb_data_o, m_data);
            end

            // state advance for the coming clock edge
            if (r_hs && hit && xif.result_we) begin
                m_bufv <= 1'b1; m_rd <= xif.result_rd; m_data <= xif.result_data;
            end else if (wb_ready_i) begin
                m_bufv <= 1'b0;
            end
            if (r_hs) m_pend[xif.result_id] <= 1'b0;
            if (e_cv && !e_ck && m_wb) m_pend[m_id] <= 1'b1;
            if (e_cv) m_busy <= 1'b0;
            if (e_iv && xif.issue_ready) begin
                m_issued <= 1'b1; m_acc <= xif.issue_accept; m_wb <= xif.issue_wb;
                m_id <= m_next; m_next <= (m_next + 1) % NIDS;
            end
            if (e_or && off_valid_i) begin
                m_busy <= 1'b1; m_issued <= 1'b0;
                m_instr <= off_instr_i; m_rs1 <= off_rs1_i; m_rs2 <= off_rs2_i;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        off_valid_i = 1'b0; off_instr_i = 32'h0; off_rs1_i = 32'h0; off_rs2_i = 32'h0;
        cmt_valid_i = 1'b0; cmt_kill_i = 1'b0;
        xif.issue_ready = 1'b0; xif.issue_accept = 1'b0; xif.issue_wb = 1'b0;
        xif.result_valid = 1'b0; xif.result_id = 4'd0; xif.result_rd = 5'd0;
        xif.result_data = 32'h0; xif.result_we = 1'b0;
        wb_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Minimum-latency offer / issue / commit of one instruction.
    task automatic do_txn(input bit acc, input bit wb, input bit kill, input int exp_id);
        step(); off_valid_i = 1'b1; off_instr_i = $urandom; off_rs1_i = $urandom; off_rs2_i = $urandom;
        @(negedge clk); check("txn_offer_ready", off_ready_o, 1'b1);
        step(); off_valid_i = 1'b0; xif.issue_ready = 1'b1; xif.issue_accept = acc; xif.issue_wb = wb;
        @(negedge clk); check("txn_issue_id", xif.issue_id, exp_id);
        step(); xif.issue_ready = 1'b0; cmt_valid_i = 1'b1; cmt_kill_i = kill;
        @(negedge clk); check("txn_commit_id", xif.commit_id, exp_id);
        step(); cmt_valid_i = 1'b0; cmt_kill_i = 1'b0;
    endtask

    initial begin
        int q[$];
        idle_inputs();
        do_reset();

        // reset state
        step();
        @(negedge clk);
        check("reset_off_ready", off_ready_o, 1'b1);
        check("reset_issue_valid", xif.issue_valid, 1'b0);
        check("reset_wb_valid", wb_valid_o, 1'b0);

        // basic offload with writeback
        step(); off_valid_i = 1'b1; off_instr_i = 32'h0A00_002B; off_rs1_i = 32'h1; off_rs2_i = 32'h2;
        @(negedge clk); check("basic_off_ready", off_ready_o, 1'b1);
        step(); off_valid_i = 1'b0; xif.issue_ready = 1'b1; xif.issue_accept = 1'b1; xif.issue_wb = 1'b1;
        @(negedge clk);
        check("basic_issue_valid", xif.issue_valid, 1'b1);
        check("basic_issue_id", xif.issue_id, 4'd0);
        check("basic_issue_instr", xif.issue_instr, 32'h0A00_002B);
        check("basic_issue_rs", xif.issue_rs, 64'h0000_0002_0000_0001);
        step(); xif.issue_ready = 1'b0; cmt_valid_i = 1'b1; cmt_kill_i = 1'b0;
        @(negedge clk);
        check("basic_commit_valid", xif.commit_valid, 1'b1);
        check("basic_commit_id", xif.commit_id, 4'd0);
        check("basic_commit_kill", xif.commit_kill, 1'b0);
        step(); cmt_valid_i = 1'b0;
        xif.result_valid = 1'b1; xif.result_id = 4'd0; xif.result_rd = 5'd5;
        xif.result_data = 32'hDEAD_BEEF; xif.result_we = 1'b1;
        @(negedge clk);
        check("basic_result_ready", xif.result_ready, 1'b1);
        check("basic_no_err", err_o, 1'b0);
        step(); xif.result_valid = 1'b0;
        @(negedge clk);
        check("basic_wb_valid", wb_valid_o, 1'b1);
        check("basic_wb_rd", wb_rd_o, 5'd5);
        check("basic_wb_data", wb_data_o, 32'hDEAD_BEEF);
        step(); wb_ready_i = 1'b1;
        step(); wb_ready_i = 1'b0;
        @(negedge clk); check("basic_wb_drained", wb_valid_o, 1'b0);

        // rejected instruction
        do_reset();
        step(); off_valid_i = 1'b1;
        step(); off_valid_i = 1'b0; xif.issue_ready = 1'b1; xif.issue_accept = 1'b0;
        @(negedge clk); check("rej_illegal", illegal_o, 1'b1);
        step(); xif.issue_ready = 1'b0;
        @(negedge clk);
        check("rej_commit_valid", xif.commit_valid, 1'b1);
        check("rej_commit_kill", xif.commit_kill, 1'b1);
        check("rej_commit_id", xif.commit_id, 4'd0);
        step(); off_valid_i = 1'b1;
        step(); off_valid_i = 1'b0;
        @(negedge clk); check("rej_next_id", xif.issue_id, 4'd1);

        // killed instruction, then a stray result
        do_reset();
        do_txn(1'b1, 1'b1, 1'b1, 0);
        xif.result_valid = 1'b1; xif.result_id = 4'd0; xif.result_we = 1'b1; xif.result_rd = 5'd3;
        @(negedge clk); check("kill_err", err_o, 1'b1);
        step(); xif.result_valid = 1'b0;
        @(negedge clk); check("kill_no_wb", wb_valid_o, 1'b0);

        // outstanding limit and buffer back-pressure
        do_reset();
        do_txn(1'b1, 1'b1, 1'b0, 0);
        do_txn(1'b1, 1'b1, 1'b0, 1);
        @(negedge clk); check("max_full", off_ready_o, 1'b0);
        step(); xif.result_valid = 1'b1; xif.result_id = 4'd0; xif.result_we = 1'b1; wb_ready_i = 1'b1;
        step(); xif.result_valid = 1'b0;
        @(negedge clk); check("max_release", off_ready_o, 1'b1);
        step(); wb_ready_i = 1'b0; xif.result_valid = 1'b1; xif.result_id = 4'd1; xif.result_data = 32'h1234_5678;
        step(); xif.result_valid = 1'b1; xif.result_id = 4'd3;
        @(negedge clk);
        check("buf_full_wb_valid", wb_valid_o, 1'b1);
        check("buf_full_stall", xif.result_ready, 1'b0);
        step(); xif.result_valid = 1'b0; wb_ready_i = 1'b1;
        step(); wb_ready_i = 1'b0;

        // id wrap stalls on a still-pending id 0
        do_reset();
        do_txn(1'b1, 1'b1, 1'b0, 0);
        for (int i = 1; i < NIDS; i++) do_txn(1'b1, 1'b0, 1'b0, i);
        off_valid_i = 1'b1;
        @(negedge clk); check("wrap_stall", off_ready_o, 1'b0);
        step(); xif.result_valid = 1'b1; xif.result_id = 4'd0; xif.result_we = 1'b1; wb_ready_i = 1'b1;
        step(); xif.result_valid = 1'b0;
        @(negedge clk); check("wrap_release", off_ready_o, 1'b1);
        step(); off_valid_i = 1'b0;
        @(negedge clk); check("wrap_issue_id", xif.issue_id, 4'd0);

        // asynchronous reset while in ISSUE
        do_reset();
        step(); off_valid_i = 1'b1;
        step(); off_valid_i = 1'b0;
        @(negedge clk); check("rst_pre_issue_valid", xif.issue_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_drop", xif.issue_valid, 1'b0);
        @(negedge clk); #1 rst_n = 1'b1;
        step(); off_valid_i = 1'b1;
        step(); off_valid_i = 1'b0;
        @(negedge clk); check("rst_id_restart", xif.issue_id, 4'd0);

        // randomized traffic checked by the model
        do_reset();
        repeat (3000) begin
            step();
            off_valid_i  = ($urandom_range(0, 1) == 0);
            off_instr_i  = $urandom; off_rs1_i = $urandom; off_rs2_i = $urandom;
            xif.issue_ready  = ($urandom_range(0, 1) == 0);
            xif.issue_accept = ($urandom_range(0, 99) < 85);
            xif.issue_wb     = ($urandom_range(0, 99) < 75);
            cmt_valid_i  = ($urandom_range(0, 1) == 0);
            cmt_kill_i   = ($urandom_range(0, 3) == 0);
            wb_ready_i   = ($urandom_range(0, 99) < 60);
            xif.result_valid = ($urandom_range(0, 99) < 40);
            q.delete();
            for (int i = 0; i < NIDS; i++) if (m_pend[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 99) < 80)
                xif.result_id = 4'(q[$urandom_range(0, q.size() - 1)]);
            else
                xif.result_id = 4'($urandom_range(0, NIDS - 1));
            xif.result_rd   = 5'($urandom_range(0, 31));
            xif.result_data = $urandom;
            xif.result_we   = ($urandom_range(0, 99) < 80);
        end
        step();
        idle_inputs();
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
